// File: rtl/decode_queue_stage.sv
// decode_queue_stage: RV32I decode stage with an instruction queue between
// fetch and execute. The head entry is decoded combinationally and issued
// into the ID/EX register. Load-use hazards insert bubbles, and i_flush
// empties the stage.
// Optional build macro DECODE_ILLEGAL_TRAP_EN adds o_illegal for unknown
// opcodes and for reserved branch funct3 values.
//
// Handshakes (valid/ready):
//   - Fetch -> queue: a beat transfers on a clock edge where i_valid && o_ready.
//   - ID/EX -> execute: the contents transfer on an edge where o_valid && i_ready.
//   - A producer keeps its payload stable while valid is high and the
//     transfer has not happened. Valid never depends combinationally on ready.
module decode_queue_stage #(
    parameter int XLEN        = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter int ALUOPS      = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [XLEN-1:0]               i_inst,
    input  logic [XLEN-1:0]               i_pc,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic                          i_flush,
    output logic [4:0]                    o_rs1_addr,
    output logic [4:0]                    o_rs2_addr,
    input  logic [XLEN-1:0]               i_rs1_data,
    input  logic [XLEN-1:0]               i_rs2_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [6:0]                    or_opcode,
    output logic [4:0]                    or_rd_addr,
    output logic [4:0]                    or_rs1_addr,
    output logic [4:0]                    or_rs2_addr,
    output logic [XLEN-1:0]               or_rs1_data,
    output logic [XLEN-1:0]               or_rs2_data,
    output logic [XLEN-1:0]               or_imm,
    output logic [2:0]                    or_funct3,
    output logic [6:0]                    or_funct7,
    output logic [ALUOPS-1:0]             or_alu_op,
    output logic [XLEN-1:0]               or_pc,
    output logic                          or_write_enable,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                          o_illegal,
`endif
    output logic [$clog2(QUEUE_DEPTH):0]  o_count
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [ALUOPS-1:0] ALU_ADD  = ALUOPS'(0);
    localparam logic [ALUOPS-1:0] ALU_SUB  = ALUOPS'(1);
    localparam logic [ALUOPS-1:0] ALU_XOR  = ALUOPS'(2);
    localparam logic [ALUOPS-1:0] ALU_OR   = ALUOPS'(3);
    localparam logic [ALUOPS-1:0] ALU_AND  = ALUOPS'(4);
    localparam logic [ALUOPS-1:0] ALU_SLL  = ALUOPS'(5);
    localparam logic [ALUOPS-1:0] ALU_SRL  = ALUOPS'(6);
    localparam logic [ALUOPS-1:0] ALU_SRA  = ALUOPS'(7);
    localparam logic [ALUOPS-1:0] ALU_SLT  = ALUOPS'(8);
    localparam logic [ALUOPS-1:0] ALU_SLTU = ALUOPS'(9);
    localparam logic [ALUOPS-1:0] ALU_EQ   = ALUOPS'(10);
    localparam logic [ALUOPS-1:0] ALU_NEQ  = ALUOPS'(11);
    localparam logic [ALUOPS-1:0] ALU_GE   = ALUOPS'(12);
    localparam logic [ALUOPS-1:0] ALU_GEU  = ALUOPS'(13);

    typedef struct packed {
        logic [6:0]        opcode;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [ALUOPS-1:0] alu_op;
        logic [XLEN-1:0]   pc;
        logic              we;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic              illegal;
`endif
    } idex_t;

    logic [XLEN-1:0]  mem_inst_q [QUEUE_DEPTH];
    logic [XLEN-1:0]  mem_pc_q   [QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    idex_t            idex_q, idex_d, dec;

    logic [XLEN-1:0]   head_inst;
    logic [6:0]        head_op;
    logic [4:0]        head_rd, head_rs1, head_rs2;
    logic [2:0]        head_f3;
    logic [6:0]        head_f7;
    logic              head_valid, head_uses_rs2, hazard, issue, enq;
    logic [ALUOPS-1:0] arith_alu;

    assign head_inst  = mem_inst_q[rd_ptr_q];
    assign head_op    = head_inst[6:0];
    assign head_rd    = head_inst[11:7];
    assign head_f3    = head_inst[14:12];
    assign head_rs1   = head_inst[19:15];
    assign head_rs2   = head_inst[24:20];
    assign head_f7    = head_inst[31:25];
    assign head_valid = (count_q != '0);

    assign o_ready    = (count_q < CNT_W'(QUEUE_DEPTH));
    assign o_rs1_addr = head_rs1;
    assign o_rs2_addr = head_rs2;
    assign o_count    = count_q;

    // Only R, S and B formats actually read rs2; rs1 is compared unconditionally.
    assign head_uses_rs2 = (head_op == OP_REG) || (head_op == OP_STORE) || (head_op == OP_BRANCH);
    assign hazard = valid_q && (idex_q.opcode == OP_LOAD) && (idex_q.rd != 5'd0) && head_valid &&
                    ((head_rs1 == idex_q.rd) || (head_uses_rs2 && (head_rs2 == idex_q.rd)));
    assign issue  = head_valid && (!valid_q || i_ready) && !hazard;
    assign enq    = i_valid && o_ready && !i_flush;

    // ALU op shared by register-register and register-immediate arithmetic.
    always_comb begin
        arith_alu = ALU_ADD;
        case (head_f3)
            3'b000: arith_alu = ((head_op == OP_REG) && (head_f7 == 7'b0100000)) ? ALU_SUB : ALU_ADD;
            3'b001: arith_alu = ALU_SLL;
            3'b010: arith_alu = ALU_SLT;
            3'b011: arith_alu = ALU_SLTU;
            3'b100: arith_alu = ALU_XOR;
            3'b101: arith_alu = (head_f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            3'b110: arith_alu = ALU_OR;
            default: arith_alu = ALU_AND;
        endcase
    end

    // Decode the queue head into the ID/EX payload; unknown opcodes become NOPs.
    always_comb begin
        dec          = '0;
        dec.opcode   = head_op;
        dec.rd       = head_rd;
        dec.rs1      = head_rs1;
        dec.rs2      = head_rs2;
        dec.rs1_data = i_rs1_data;
        dec.rs2_data = i_rs2_data;
        dec.funct3   = head_f3;
        dec.funct7   = head_f7;
        dec.pc       = mem_pc_q[rd_ptr_q];
        dec.alu_op   = ALU_ADD;
        case (head_op)
            OP_LUI, OP_AUIPC: begin
                dec.imm = {{(XLEN-31){head_inst[31]}}, head_inst[30:12], 12'b0};
                dec.we  = (head_rd != 5'd0);
            end
            OP_JAL: begin
                dec.imm = {{(XLEN-20){head_inst[31]}}, head_inst[19:12], head_inst[20],
                           head_inst[30:21], 1'b0};
                dec.we  = (head_rd != 5'd0);
            end
            OP_JALR, OP_LOAD: begin
                dec.imm = {{(XLEN-11){head_inst[31]}}, head_inst[30:20]};
                dec.we  = (head_rd != 5'd0);
            end
            OP_STORE: begin
                dec.imm = {{(XLEN-11){head_inst[31]}}, head_inst[30:25], head_inst[11:7]};
            end
            OP_BRANCH: begin
                dec.imm = {{(XLEN-12){head_inst[31]}}, head_inst[7], head_inst[30:25],
                           head_inst[11:8], 1'b0};
                case (head_f3)
                    3'b000: dec.alu_op = ALU_EQ;
                    3'b001: dec.alu_op = ALU_NEQ;
                    3'b100: dec.alu_op = ALU_SLT;
                    3'b101: dec.alu_op = ALU_GE;
                    3'b110: dec.alu_op = ALU_SLTU;
                    3'b111: dec.alu_op = ALU_GEU;
                    default: begin
                        dec.alu_op = ALU_ADD;
`ifdef DECODE_ILLEGAL_TRAP_EN
                        dec.illegal = 1'b1;
`endif
                    end
                endcase
            end
            OP_IMM: begin
                dec.imm    = {{(XLEN-11){head_inst[31]}}, head_inst[30:20]};
                dec.alu_op = arith_alu;
                dec.we     = (head_rd != 5'd0);
            end
            OP_REG: begin
                dec.alu_op = arith_alu;
                dec.we     = (head_rd != 5'd0);
            end
            OP_FENCE, OP_SYSTEM: begin
                dec.imm = '0;
            end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                dec.illegal = 1'b1;
`endif
            end
        endcase
    end

    // Queue pointer/occupancy next state; flush wins over enqueue and issue.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (issue) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({enq, issue})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ID/EX next state: flush clears valid, issue loads, accept without issue drains.
    always_comb begin
        valid_d = valid_q;
        idex_d  = idex_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (issue) begin
            valid_d = 1'b1;
            idex_d  = dec;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    // Queue storage write port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem_inst_q[i] <= '0;
                mem_pc_q[i]   <= '0;
            end
        end else if (enq) begin
            mem_inst_q[wr_ptr_q] <= i_inst;
            mem_pc_q[wr_ptr_q]   <= i_pc;
        end
    end

    // State registers for queue control and the ID/EX stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            idex_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            idex_q   <= idex_d;
        end
    end

    assign o_valid         = valid_q;
    assign or_opcode       = idex_q.opcode;
    assign or_rd_addr      = idex_q.rd;
    assign or_rs1_addr     = idex_q.rs1;
    assign or_rs2_addr     = idex_q.rs2;
    assign or_rs1_data     = idex_q.rs1_data;
    assign or_rs2_data     = idex_q.rs2_data;
    assign or_imm          = idex_q.imm;
    assign or_funct3       = idex_q.funct3;
    assign or_funct7       = idex_q.funct7;
    assign or_alu_op       = idex_q.alu_op;
    assign or_pc           = idex_q.pc;
    assign or_write_enable = idex_q.we;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign o_illegal       = idex_q.illegal;
`endif

endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed testbench for decode_queue_stage (XLEN=32, QUEUE_DEPTH=4).
module tb_decode_queue_stage;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SRA = 4'd7, A_NEQ = 4'd11;

    logic        clk, rst_n;
    logic [31:0] i_inst, i_pc, rs1_data, rs2_data;
    logic        i_valid, o_ready, i_flush, o_valid, i_ready;
    logic [4:0]  o_rs1_addr, o_rs2_addr, or_rd_addr, or_rs1_addr, or_rs2_addr;
    logic [6:0]  or_opcode, or_funct7;
    logic [31:0] or_rs1_data, or_rs2_data, or_imm, or_pc;
    logic [2:0]  or_funct3;
    logic [3:0]  or_alu_op;
    logic        or_write_enable;
    logic [2:0]  o_count;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        o_illegal;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Register file stand-in: read data tags the address so it can be predicted.
    assign rs1_data = 32'hA000_0000 | {27'd0, o_rs1_addr};
    assign rs2_data = 32'hB000_0000 | {27'd0, o_rs2_addr};

    decode_queue_stage #(.XLEN(32), .QUEUE_DEPTH(4), .ALUOPS(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_inst(i_inst), .i_pc(i_pc), .i_valid(i_valid),
        .o_ready(o_ready), .i_flush(i_flush), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
        .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .o_valid(o_valid), .i_ready(i_ready),
        .or_opcode(or_opcode), .or_rd_addr(or_rd_addr), .or_rs1_addr(or_rs1_addr),
        .or_rs2_addr(or_rs2_addr), .or_rs1_data(or_rs1_data), .or_rs2_data(or_rs2_data),
        .or_imm(or_imm), .or_funct3(or_funct3), .or_funct7(or_funct7), .or_alu_op(or_alu_op),
        .or_pc(or_pc), .or_write_enable(or_write_enable),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .o_illegal(o_illegal),
`endif
        .o_count(o_count)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq_one(input logic [31:0] inst, input logic [31:0] pc);
        i_valid = 1'b1; i_inst = inst; i_pc = pc;
        step();
        i_valid = 1'b0;
    endtask

    function automatic logic [31:0] addi_k(input int k);
        return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        i_inst = '0; i_pc = '0;
        #3;
        tests_run++; if (o_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", o_count); end
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        tests_run++; if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b exp 1", o_ready); end
        tests_run++; if (or_imm !== 32'd0) begin tests_failed++; $display("FAIL reset_imm got %h exp 0", or_imm); end
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_addi();
        i_ready = 1'b1;
        enq_one(32'h0050_0093, 32'h100);
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL addi_latency got %b exp 0", o_valid); end
        tests_run++; if (o_count !== 3'd1) begin tests_failed++; $display("FAIL addi_count1 got %0d exp 1", o_count); end
        step();
        tests_run++; if (o_valid !== 1'b1) begin tests_failed++; $display("FAIL addi_valid got %b exp 1", o_valid); end
        tests_run++; if (or_imm !== 32'd5) begin tests_failed++; $display("FAIL addi_imm got %h exp 5", or_imm); end
        tests_run++; if (or_alu_op !== A_ADD) begin tests_failed++; $display("FAIL addi_alu got %0d exp %0d", or_alu_op, A_ADD); end
        tests_run++; if (or_rd_addr !== 5'd1) begin tests_failed++; $display("FAIL addi_rd got %0d exp 1", or_rd_addr); end
        tests_run++; if (or_write_enable !== 1'b1) begin tests_failed++; $display("FAIL addi_we got %b exp 1", or_write_enable); end
        tests_run++; if (or_opcode !== 7'h13) begin tests_failed++; $display("FAIL addi_opcode got %h exp 13", or_opcode); end
        tests_run++; if (or_pc !== 32'h100) begin tests_failed++; $display("FAIL addi_pc got %h exp 100", or_pc); end
        tests_run++; if (or_rs1_data !== 32'hA000_0000) begin tests_failed++; $display("FAIL addi_rs1_data got %h exp a0000000", or_rs1_data); end
        tests_run++; if (o_count !== 3'd0) begin tests_failed++; $display("FAIL addi_count0 got %0d exp 0", o_count); end
        step();
    endtask

    task automatic test_alu_ops();
        i_ready = 1'b1;
        i_valid = 1'b1; i_inst = 32'h4020_81B3; i_pc = 32'h200;
        step();
        i_inst = 32'h4030_D213; i_pc = 32'h204;
        step();
        i_valid = 1'b0;
        tests_run++; if (or_alu_op !== A_SUB) begin tests_failed++; $display("FAIL sub_alu got %0d exp %0d", or_alu_op, A_SUB); end
        tests_run++; if (or_rd_addr !== 5'd3) begin tests_failed++; $display("FAIL sub_rd got %0d exp 3", or_rd_addr); end
        tests_run++; if (or_imm !== 32'd0) begin tests_failed++; $display("FAIL sub_imm got %h exp 0", or_imm); end
        tests_run++; if (or_rs2_data !== 32'hB000_0002) begin tests_failed++; $display("FAIL sub_rs2_data got %h exp b0000002", or_rs2_data); end
        tests_run++; if (or_funct7 !== 7'h20) begin tests_failed++; $display("FAIL sub_funct7 got %h exp 20", or_funct7); end
        step();
        tests_run++; if (or_alu_op !== A_SRA) begin tests_failed++; $display("FAIL srai_alu got %0d exp %0d", or_alu_op, A_SRA); end
        tests_run++; if (or_imm !== 32'h403) begin tests_failed++; $display("FAIL srai_imm got %h exp 403", or_imm); end
        tests_run++; if (or_rd_addr !== 5'd4) begin tests_failed++; $display("FAIL srai_rd got %0d exp 4", or_rd_addr); end
        tests_run++; if (or_funct3 !== 3'd5) begin tests_failed++; $display("FAIL srai_funct3 got %0d exp 5", or_funct3); end
        tests_run++; if (or_pc !== 32'h204) begin tests_failed++; $display("FAIL srai_pc got %h exp 204", or_pc); end
        step();
    endtask

    task automatic test_immediates();
        logic [31:0] insts [4];
        logic [31:0] imms  [4];
        logic [3:0]  alus  [4];
        logic        wes   [4];
        insts[0] = 32'h1234_52B7; imms[0] = 32'h1234_5000; alus[0] = A_ADD; wes[0] = 1'b1; // LUI x5
        insts[1] = 32'hFFDF_F0EF; imms[1] = 32'hFFFF_FFFC; alus[1] = A_ADD; wes[1] = 1'b1; // JAL x1,-4
        insts[2] = 32'hFE20_AC23; imms[2] = 32'hFFFF_FFF8; alus[2] = A_ADD; wes[2] = 1'b0; // SW x2,-8(x1)
        insts[3] = 32'hFE20_98E3; imms[3] = 32'hFFFF_FFF0; alus[3] = A_NEQ; wes[3] = 1'b0; // BNE x1,x2,-16
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enq_one(insts[i], 32'h400 + 32'(i * 4));
            step();
            tests_run++; if (or_imm !== imms[i]) begin tests_failed++; $display("FAIL imm_%0d got %h exp %h", i, or_imm, imms[i]); end
            tests_run++; if (or_alu_op !== alus[i]) begin tests_failed++; $display("FAIL imm_alu_%0d got %0d exp %0d", i, or_alu_op, alus[i]); end
            tests_run++; if (or_write_enable !== wes[i]) begin tests_failed++; $display("FAIL imm_we_%0d got %b exp %b", i, or_write_enable, wes[i]); end
        end
        step();
    endtask

    task automatic test_load_use();
        i_ready = 1'b1;
        i_valid = 1'b1; i_inst = 32'h0000_A103; i_pc = 32'h300;
        step();
        i_inst = 32'h0021_01B3; i_pc = 32'h304;
        step();
        i_valid = 1'b0;
        tests_run++; if (o_valid !== 1'b1 || or_opcode !== 7'h03) begin tests_failed++; $display("FAIL lw_issue got v=%b op=%h exp v=1 op=03", o_valid, or_opcode); end
        tests_run++; if (or_rd_addr !== 5'd2) begin tests_failed++; $display("FAIL lw_rd got %0d exp 2", or_rd_addr); end
        step();
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL lu_bubble got %b exp 0", o_valid); end
        tests_run++; if (o_count !== 3'd1) begin tests_failed++; $display("FAIL lu_count got %0d exp 1", o_count); end
        step();
        tests_run++; if (o_valid !== 1'b1 || or_pc !== 32'h304) begin tests_failed++; $display("FAIL lu_resume got v=%b pc=%h exp v=1 pc=304", o_valid, or_pc); end
        tests_run++; if (or_rd_addr !== 5'd3) begin tests_failed++; $display("FAIL lu_add_rd got %0d exp 3", or_rd_addr); end
        tests_run++; if (or_rs1_data !== 32'hA000_0002) begin tests_failed++; $display("FAIL lu_add_rs1 got %h exp a0000002", or_rs1_data); end
        step();
        // Independent follower: no bubble expected
        i_valid = 1'b1; i_inst = 32'h0000_A103; i_pc = 32'h310;
        step();
        i_inst = 32'h0050_0093; i_pc = 32'h314;
        step();
        i_valid = 1'b0;
        step();
        tests_run++; if (o_valid !== 1'b1 || or_pc !== 32'h314) begin tests_failed++; $display("FAIL lu_nodep got v=%b pc=%h exp v=1 pc=314", o_valid, or_pc); end
        step();
    endtask

    task automatic test_stall_full();
        int sent = 0;
        int got = 0;
        logic fire;
        i_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            i_valid = (sent < 6); i_inst = addi_k(sent + 1); i_pc = 32'h500 + 32'(sent * 4);
            fire = i_valid && o_ready;
            step();
            if (fire) sent++;
        end
        tests_run++; if (sent != 5) begin tests_failed++; $display("FAIL full_accepted got %0d exp 5", sent); end
        tests_run++; if (o_count !== 3'd4) begin tests_failed++; $display("FAIL full_count got %0d exp 4", o_count); end
        tests_run++; if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready got %b exp 0", o_ready); end
        tests_run++; if (o_valid !== 1'b1 || or_imm !== 32'd1) begin tests_failed++; $display("FAIL stall_hold got v=%b imm=%h exp v=1 imm=1", o_valid, or_imm); end
        i_ready = 1'b1;
        for (int c = 0; c < 20 && got < 5; c++) begin
            i_valid = (sent < 6); i_inst = addi_k(sent + 1); i_pc = 32'h500 + 32'(sent * 4);
            fire = i_valid && o_ready;
            step();
            if (fire) sent++;
            if (o_valid) begin
                tests_run++;
                if (or_imm !== 32'(got + 2) || or_rd_addr !== 5'(got + 2)) begin
                    tests_failed++;
                    $display("FAIL drain_%0d got imm=%h rd=%0d exp %0d", got, or_imm, or_rd_addr, got + 2);
                end
                got++;
            end
        end
        i_valid = 1'b0;
        tests_run++; if (got != 5 || sent != 6) begin tests_failed++; $display("FAIL drain_total got %0d/%0d exp 5/6", got, sent); end
        tests_run++; if (o_count !== 3'd0) begin tests_failed++; $display("FAIL drain_count got %0d exp 0", o_count); end
        step();
        tests_run++; if (o_valid !== 1'b0 || or_imm !== 32'd6) begin tests_failed++; $display("FAIL drain_hold got v=%b imm=%h exp v=0 imm=6", o_valid, or_imm); end
    endtask

    task automatic test_flush();
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            enq_one(addi_k(k + 1), 32'h600 + 32'(k * 4));
        end
        tests_run++; if (o_count !== 3'd3 || o_valid !== 1'b1) begin tests_failed++; $display("FAIL flush_pre got cnt=%0d v=%b exp 3/1", o_count, o_valid); end
        i_flush = 1'b1; i_valid = 1'b1; i_inst = addi_k(9);
        step();
        i_flush = 1'b0; i_valid = 1'b0;
        tests_run++; if (o_count !== 3'd0) begin tests_failed++; $display("FAIL flush_count got %0d exp 0", o_count); end
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_valid got %b exp 0", o_valid); end
        step();
        tests_run++; if (o_count !== 3'd0 || o_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_discard got cnt=%0d v=%b exp 0/0", o_count, o_valid); end
        i_ready = 1'b1;
        enq_one(32'hFFFF_FFFF, 32'h700);
        step();
        tests_run++; if (o_valid !== 1'b1 || or_write_enable !== 1'b0) begin tests_failed++; $display("FAIL unk_we got v=%b we=%b exp v=1 we=0", o_valid, or_write_enable); end
        tests_run++; if (or_alu_op !== A_ADD) begin tests_failed++; $display("FAIL unk_alu got %0d exp 0", or_alu_op); end
`ifdef DECODE_ILLEGAL_TRAP_EN
        tests_run++; if (o_illegal !== 1'b1) begin tests_failed++; $display("FAIL unk_illegal got %b exp 1", o_illegal); end
`else
        tests_run++; if (or_imm !== 32'd0) begin tests_failed++; $display("FAIL unk_imm got %h exp 0", or_imm); end
`endif
        step();
    endtask

    task automatic test_reset_midstream();
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            enq_one(addi_k(k + 1), 32'h800 + 32'(k * 4));
        end
        tests_run++; if (o_count !== 3'd3 || o_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_pre got cnt=%0d v=%b exp 3/1", o_count, o_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (o_count !== 3'd0) begin tests_failed++; $display("FAIL mid_count got %0d exp 0", o_count); end
        tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid got %b exp 0", o_valid); end
        tests_run++; if (or_imm !== 32'd0 || or_pc !== 32'd0 || or_rd_addr !== 5'd0 || or_opcode !== 7'd0)
            begin tests_failed++; $display("FAIL mid_fields got imm=%h pc=%h rd=%0d op=%h exp 0", or_imm, or_pc, or_rd_addr, or_opcode); end
        tests_run++; if (or_write_enable !== 1'b0 || or_rs1_data !== 32'd0 || or_alu_op !== 4'd0)
            begin tests_failed++; $display("FAIL mid_ctrl got we=%b rs1=%h alu=%0d exp 0", or_write_enable, or_rs1_data, or_alu_op); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_alu_ops();
        test_immediates();
        test_load_use();
        test_stall_full();
        test_flush();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
